// File: rtl/cpu_sram_bridge_pkg.sv
// Shared types and helpers for the CPU-to-SRAM bridge: FSM state encoding
// and the kseg0/kseg1 virtual-to-physical address mapping.
package cpu_sram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    // kseg0 (0x8xxx_xxxx/0x9xxx_xxxx) and kseg1 (0xAxxx_xxxx/0xBxxx_xxxx)
    // both alias the low 512 MB of physical space.
    function automatic logic [31:0] map_addr(input logic [31:0] vaddr, input bit map_en);
        if (map_en && (vaddr[31:30] == 2'b10)) begin
            return vaddr & KSEG_MASK;
        end
        return vaddr;
    endfunction

endpackage

// File: rtl/cpu_sram_bridge_if.sv
// Bundles the CPU-side inst/data sram ports and the merged memory port.
// The bridge uses the slave view; the CPU/memory side uses the master view.
interface cpu_sram_bridge_if;

    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        cpu_stall;

    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_rdata, data_rdata, cpu_stall,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_rdata, data_rdata, cpu_stall,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cpu_sram_bridge_addr_map.sv
// Combinational virtual-to-physical address translation for one CPU port.
module cpu_sram_bridge_addr_map
    import cpu_sram_bridge_pkg::*;
#(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic [31:0] i_vaddr,
    output logic [31:0] o_paddr
);

    assign o_paddr = map_addr(i_vaddr, ADDR_MAP_EN);

endmodule

// File: rtl/cpu_sram_bridge.sv
// Merges the CPU inst and data sram ports onto one req/addr_ok/data_ok memory
// port, one transaction at a time, data first, stalling the pipeline meanwhile.
module cpu_sram_bridge
    import cpu_sram_bridge_pkg::*;
#(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    cpu_sram_bridge_if.slave bus
);

    state_e      r_state;
    state_e      w_next_state;

    logic        r_inst_en;
    logic [31:0] r_inst_addr;
    logic [31:0] r_data_addr;
    logic [3:0]  r_data_wen;
    logic [31:0] r_data_wdata;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    logic        w_cpu_req;
    logic        w_latch;
    logic [31:0] w_inst_paddr;
    logic [31:0] w_data_paddr;

    logic        w_mem_req;
    logic        w_mem_wr;
    logic [3:0]  w_mem_wstrb;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_cpu_stall;

    assign w_cpu_req = bus.inst_en | bus.data_en;
    assign w_latch   = (r_state == IDLE) && w_cpu_req;

    cpu_sram_bridge_addr_map #(.ADDR_MAP_EN(ADDR_MAP_EN)) u_inst_map (
        .i_vaddr (r_inst_addr),
        .o_paddr (w_inst_paddr)
    );

    cpu_sram_bridge_addr_map #(.ADDR_MAP_EN(ADDR_MAP_EN)) u_data_map (
        .i_vaddr (r_data_addr),
        .o_paddr (w_data_paddr)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves a latch.
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_cpu_req)       w_next_state = bus.data_en ? D_REQ : I_REQ;
            D_REQ:   if (bus.mem_addr_ok) w_next_state = D_WAIT;
            D_WAIT:  if (bus.mem_data_ok) w_next_state = r_inst_en ? I_REQ : DONE;
            I_REQ:   if (bus.mem_addr_ok) w_next_state = I_WAIT;
            I_WAIT:  if (bus.mem_data_ok) w_next_state = DONE;
            DONE:                         w_next_state = IDLE;
            default:                      w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_wstrb = 4'b0000;
        w_mem_addr  = 32'h0;
        w_mem_wdata = 32'h0;
        w_cpu_stall = 1'b1;
        unique case (r_state)
            IDLE: w_cpu_stall = w_cpu_req;
            DONE: w_cpu_stall = 1'b0;
            D_REQ: begin
                w_mem_req   = 1'b1;
                w_mem_wr    = |r_data_wen;
                w_mem_wstrb = r_data_wen;
                w_mem_addr  = w_data_paddr;
                w_mem_wdata = r_data_wdata;
            end
            I_REQ: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_inst_paddr;
            end
            default: ;
        endcase
    end

    // Request fields are captured once per CPU cycle and held until DONE,
    // so the CPU inputs may change freely while the bridge is busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_en    <= 1'b0;
            r_inst_addr  <= 32'h0;
            r_data_addr  <= 32'h0;
            r_data_wen   <= 4'b0000;
            r_data_wdata <= 32'h0;
        end else if (w_latch) begin
            r_inst_en    <= bus.inst_en;
            r_inst_addr  <= bus.inst_addr;
            r_data_addr  <= bus.data_addr;
            r_data_wen   <= bus.data_wen;
            r_data_wdata <= bus.data_wdata;
        end
    end

    // Responses are accepted only in the WAIT states; stray data_ok is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            if ((r_state == D_WAIT) && bus.mem_data_ok && (r_data_wen == 4'b0000)) begin
                r_data_rdata <= bus.mem_rdata;
            end
            if ((r_state == I_WAIT) && bus.mem_data_ok) begin
                r_inst_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_wr     = w_mem_wr;
    assign bus.mem_wstrb  = w_mem_wstrb;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.cpu_stall  = w_cpu_stall;
    assign bus.inst_rdata = r_inst_rdata;
    assign bus.data_rdata = r_data_rdata;

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Self-checking bench for cpu_sram_bridge: directed scenarios plus randomized
// access pairs against a transaction-level model of the bridge.
module tb_cpu_sram_bridge;

    typedef struct {
        bit          is_inst;
        bit          wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    cpu_sram_bridge_if bus ();
    cpu_sram_bridge_if bus_nm ();

    cpu_sram_bridge #(.ADDR_MAP_EN(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    cpu_sram_bridge #(.ADDR_MAP_EN(1'b0)) dut_nm (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_nm)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_inst_rdata = 32'h0;
    logic [31:0] exp_data_rdata = 32'h0;

    // kseg0 starts at 0x8000_0000, kseg1 at 0xA000_0000; each is 512 MB.
    function automatic logic [31:0] model_map(input logic [31:0] va, input bit en);
        if (!en) return va;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        return va;
    endfunction

    task automatic idle_inputs();
        bus.inst_en     = 1'b0;
        bus.inst_addr   = 32'h0;
        bus.data_en     = 1'b0;
        bus.data_wen    = 4'b0000;
        bus.data_addr   = 32'h0;
        bus.data_wdata  = 32'h0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
    endtask

    // One CPU cycle's worth of accesses; ad/dd are the addr_ok/data_ok delays.
    task automatic do_access(input bit ien, input logic [31:0] iaddr,
                             input bit den, input logic [3:0] wen,
                             input logic [31:0] daddr, input logic [31:0] wdata,
                             input int ad, input int dd, input bit noise,
                             input logic [31:0] rd_data, input logic [31:0] rd_inst);
        txn_t q[$];
        txn_t t;
        if (den) begin
            t.is_inst = 1'b0; t.wr = (wen != 4'b0000); t.strb = wen;
            t.addr = model_map(daddr, 1'b1); t.wdata = wdata;
            q.push_back(t);
        end
        if (ien) begin
            t.is_inst = 1'b1; t.wr = 1'b0; t.strb = 4'b0000;
            t.addr = model_map(iaddr, 1'b1); t.wdata = 32'h0;
            q.push_back(t);
        end

        @(negedge clk);
        bus.inst_en = ien; bus.inst_addr = iaddr;
        bus.data_en = den; bus.data_wen = wen; bus.data_addr = daddr; bus.data_wdata = wdata;
        #1;
        checks++;
        if (bus.cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_on_request: got %b expected 1", bus.cpu_stall);
        end
        @(posedge clk); #1;
        // Inputs are scrambled after the latching edge; the bridge must ignore them.
        bus.inst_en = 1'b0; bus.data_en = 1'b0;
        bus.inst_addr = $urandom; bus.data_addr = $urandom;
        bus.data_wen = 4'($urandom); bus.data_wdata = $urandom;

        foreach (q[i]) begin
            for (int c = 0; c <= ad; c++) begin
                @(negedge clk);
                checks++;
                if (bus.mem_req !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.mem_wr !== q[i].wr ||
                    bus.mem_wstrb !== q[i].strb || bus.mem_addr !== q[i].addr ||
                    (q[i].wr && bus.mem_wdata !== q[i].wdata)) begin
                    errors++;
                    $display("FAIL req_phase[%0d] cyc %0d: got req=%b stall=%b wr=%b strb=%h addr=%h wdata=%h expected req=1 stall=1 wr=%b strb=%h addr=%h wdata=%h",
                             i, c, bus.mem_req, bus.cpu_stall, bus.mem_wr, bus.mem_wstrb, bus.mem_addr,
                             bus.mem_wdata, q[i].wr, q[i].strb, q[i].addr, q[i].wdata);
                end
                bus.mem_addr_ok = (c == ad);
                bus.mem_data_ok = noise && (c != ad) && ($urandom_range(0, 1) == 1);
                bus.mem_rdata   = $urandom;
                @(posedge clk); #1;
                bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
            end
            for (int c = 0; c <= dd; c++) begin
                @(negedge clk);
                checks++;
                if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_phase[%0d] cyc %0d: got req=%b stall=%b expected req=0 stall=1",
                             i, c, bus.mem_req, bus.cpu_stall);
                end
                bus.mem_data_ok = (c == dd);
                bus.mem_rdata   = q[i].is_inst ? rd_inst : rd_data;
                @(posedge clk); #1;
                bus.mem_data_ok = 1'b0;
            end
            if (q[i].is_inst) exp_inst_rdata = rd_inst;
            else if (!q[i].wr) exp_data_rdata = rd_data;
        end

        @(negedge clk);
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: got stall=%b req=%b expected stall=0 req=0", bus.cpu_stall, bus.mem_req);
        end
        checks++;
        if (bus.inst_rdata !== exp_inst_rdata || bus.data_rdata !== exp_data_rdata) begin
            errors++;
            $display("FAIL rdata: got inst=%h data=%h expected inst=%h data=%h",
                     bus.inst_rdata, bus.data_rdata, exp_inst_rdata, exp_data_rdata);
        end
        bus.mem_data_ok = noise;
        bus.mem_rdata   = $urandom;
        @(posedge clk); #1;
        bus.mem_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0 ||
            bus.inst_rdata !== exp_inst_rdata || bus.data_rdata !== exp_data_rdata) begin
            errors++;
            $display("FAIL idle_hold: got stall=%b req=%b inst=%h data=%h expected stall=0 req=0 inst=%h data=%h",
                     bus.cpu_stall, bus.mem_req, bus.inst_rdata, bus.data_rdata, exp_inst_rdata, exp_data_rdata);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        bus_nm.inst_en = 1'b0; bus_nm.inst_addr = 32'h0; bus_nm.data_en = 1'b0;
        bus_nm.data_wen = 4'b0000; bus_nm.data_addr = 32'h0; bus_nm.data_wdata = 32'h0;
        bus_nm.mem_addr_ok = 1'b0; bus_nm.mem_data_ok = 1'b0; bus_nm.mem_rdata = 32'h0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_wstrb !== 4'b0000 ||
            bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.cpu_stall !== 1'b0 ||
            bus.inst_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: got req=%b wr=%b strb=%h addr=%h wdata=%h stall=%b inst=%h data=%h expected all zero",
                     bus.mem_req, bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
                     bus.cpu_stall, bus.inst_rdata, bus.data_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_fetch_only();
        do_access(1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 0, 1'b0,
                  32'h0, 32'h3C1D_8000);
    endtask

    task automatic test_load_fetch();
        do_access(1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_1004, 32'h0, 0, 0, 1'b0,
                  32'hDEAD_BEEF, 32'h2408_0001);
    endtask

    task automatic test_byte_store();
        do_access(1'b0, 32'h0, 1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000, 1, 1, 1'b0,
                  32'h1234_5678, 32'h0);
    endtask

    task automatic test_backpressure();
        do_access(1'b1, 32'h8000_0100, 1'b1, 4'b1111, 32'hA000_0040, 32'hCAFE_F00D, 7, 2, 1'b1,
                  32'h0, 32'h0BAD_C0DE);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  iseg, dseg;
            logic [31:0] ia, da;
            bit          ien, den;
            logic [3:0]  wen;
            ien  = ($urandom_range(0, 1) == 1);
            den  = ($urandom_range(0, 1) == 1);
            if (!ien && !den) ien = 1'b1;
            iseg = 2'($urandom); dseg = 2'($urandom);
            ia   = {iseg, 30'($urandom)};
            da   = {dseg, 30'($urandom)};
            wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            do_access(ien, ia, den, wen, da, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'b1, $urandom, $urandom);
        end
    endtask

    task automatic test_no_map();
        logic [31:0] rd;
        rd = $urandom | 32'h1;
        @(negedge clk);
        bus_nm.data_en = 1'b1; bus_nm.data_wen = 4'b0000; bus_nm.data_addr = 32'hA000_0010;
        @(posedge clk); #1;
        bus_nm.data_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_nm.mem_req !== 1'b1 || bus_nm.mem_addr !== 32'hA000_0010) begin
            errors++;
            $display("FAIL no_map_addr: got req=%b addr=%h expected req=1 addr=a0000010",
                     bus_nm.mem_req, bus_nm.mem_addr);
        end
        bus_nm.mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_nm.mem_addr_ok = 1'b0;
        @(negedge clk);
        bus_nm.mem_data_ok = 1'b1; bus_nm.mem_rdata = rd;
        @(posedge clk); #1;
        bus_nm.mem_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_nm.cpu_stall !== 1'b0 || bus_nm.data_rdata !== rd) begin
            errors++;
            $display("FAIL no_map_done: got stall=%b data=%h expected stall=0 data=%h",
                     bus_nm.cpu_stall, bus_nm.data_rdata, rd);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.data_en = 1'b1; bus.data_wen = 4'b0000; bus.data_addr = 32'h8000_3000;
        @(posedge clk); #1;
        bus.data_en = 1'b0;
        @(negedge clk);
        bus.mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.mem_addr_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_wait: got req=%b stall=%b expected req=0 stall=1", bus.mem_req, bus.cpu_stall);
        end
        resetn = 1'b0;
        #1;
        exp_inst_rdata = 32'h0;
        exp_data_rdata = 32'h0;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0 ||
            bus.inst_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got req=%b stall=%b inst=%h data=%h expected all zero",
                     bus.mem_req, bus.cpu_stall, bus.inst_rdata, bus.data_rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hFEED_FACE;
        @(posedge clk); #1;
        bus.mem_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.data_rdata !== 32'h0 || bus.inst_rdata !== 32'h0 ||
            bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stale_data_ok: got data=%h inst=%h stall=%b req=%b expected data=0 inst=0 stall=0 req=0",
                     bus.data_rdata, bus.inst_rdata, bus.cpu_stall, bus.mem_req);
        end
        do_access(1'b1, 32'h9000_0020, 1'b1, 4'b0000, 32'hB000_0080, 32'h0, 1, 0, 1'b0,
                  32'h5555_AAAA, 32'hAAAA_5555);
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_load_fetch();
        test_byte_store();
        test_backpressure();
        test_random();
        test_no_map();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sram_bridge.md
Name: cpu_sram_bridge

Overview:
- Sits directly downstream of the CPU core's two sram-style ports (inst and data).
- Merges both ports onto one sram-like memory port with a req/addr_ok/data_ok handshake, performs kseg0/kseg1 address mapping, and serialises the accesses.
- Produces a stall so the pipeline freezes until each cycle's accesses complete.
- One outstanding memory transaction at a time; data access has priority over instruction fetch.

Parameters:
- ADDR_MAP_EN, 1, when 1 any address with addr[31:30]==2'b10 is mapped to {3'b0, addr[28:0]}; when 0 the address passes through unchanged.

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_en  in  1  fetch request for this CPU cycle
- inst_addr  in  32  fetch virtual address (PCF)
- inst_rdata  out  32  fetched word, registered
- data_en  in  1  data access request for this CPU cycle
- data_wen  in  4  byte write enables; 4'b0000 means read
- data_addr  in  32  data virtual address
- data_wdata  in  32  store data
- data_rdata  out  32  load word, registered
- cpu_stall  out  1  freezes the whole pipeline while high
- mem_req  out  1  memory request valid
- mem_wr  out  1  1 means write
- mem_wstrb  out  4  byte strobes (equal to data_wen for writes; 0 for reads)
- mem_addr  out  32  mapped physical address
- mem_wdata  out  32  write data
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  transaction complete; mem_rdata valid
- mem_rdata  in  32  read data

Behaviour:
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
- Reset (asynchronous, effective immediately): state=IDLE, mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, inst_rdata=0, data_rdata=0, pending flags cleared. cpu_stall follows its combinational rule; in IDLE with no requests it is 0.
- IDLE: when inst_en or data_en is high, latch both enables plus addresses, wen and wdata.
  - Go to D_REQ if data_en, else to I_REQ.
  - cpu_stall=1 in that cycle.
- D_REQ: mem_req=1 and the mem_* fields are driven from the latched data request.
  - Hold until mem_addr_ok=1, then go to D_WAIT.
- D_WAIT: mem_req=0. On mem_data_ok:
  - For a read, data_rdata<=mem_rdata; for a write, data_rdata is unchanged.
  - Go to I_REQ if the latched inst_en is set, else go to DONE.
- I_REQ and I_WAIT: same rules as the data states; mem_wr=0 and mem_wstrb=0; on data_ok, inst_rdata<=mem_rdata and go to DONE.
- DONE: cpu_stall=0 for exactly one cycle (the CPU advances on this edge); go to IDLE.
- cpu_stall = (state not in {IDLE, DONE}) | (state==IDLE & (inst_en|data_en)).
- Minimum latency: an access pair with addr_ok and data_ok each returned one cycle after being awaited costs 6 cycles from IDLE to DONE. A fetch alone costs 4.
- mem_data_ok is sampled only in the WAIT states. A data_ok arriving in any other state (including a stale response after reset) is ignored. data_ok must never coincide with the addr_ok of the same transaction.
- Latched request fields are not re-sampled from CPU inputs until the next IDLE.
- inst_rdata and data_rdata hold their values between transactions.
- Address mapping applies identically to inst_addr and data_addr. Mapping 0xBFC00000 gives 0x1FC00000; 0x80001000 gives 0x00001000; 0x00400000 is unchanged.

Decomposition:
- Shared package holds:
  - the state enum (6 states, 3-bit encoding);
  - constant KSEG_MASK = 32'h1FFF_FFFF;
  - the address-mapping function used by both ports.
- One natural sub-module: addr_map (combinational virtual-to-physical mapping, parameterised by ADDR_MAP_EN), instantiated twice.
- Everything else stays flat.

Test Plan:
- Reset mid-operation: drop resetn low while in D_WAIT -> mem_req=0 and state IDLE immediately. Then pulse mem_data_ok one cycle after release -> ignored; data_rdata stays 0.
- Fetch only: inst_en=1, inst_addr=0xBFC00000; memory gives addr_ok after 1 cycle and data_ok with 0x3C1D8000 one cycle later -> mem_addr=0x1FC00000, mem_wr=0, inst_rdata=0x3C1D8000, cpu_stall low for exactly one cycle (DONE).
- Load plus fetch: data_en=1, data_wen=0, data_addr=0x80001004, inst_en=1 -> data transaction first (mem_addr=0x00001004), then fetch. data_rdata=0xDEADBEEF and inst_rdata as returned; stall high for 5 cycles.
- Byte store: data_wen=4'b0100, data_wdata=0x00AB0000, data_addr=0x00002000 -> mem_wr=1, mem_wstrb=4'b0100, mem_wdata=0x00AB0000; data_rdata unchanged.
- Backpressure: hold mem_addr_ok=0 for 7 cycles in D_REQ -> mem_req and all mem_* fields stable throughout, cpu_stall=1; proceeds on the first addr_ok.
- ADDR_MAP_EN=0: data_addr=0xA0000010 -> mem_addr=0xA0000010.
